// File: rtl/neuron_input_packer.sv
// Packs sign-magnitude samples, one per beat, into a LANES*DW vector for the Neuron/MAC62 datapath.
// Latency: m_valid rises the cycle after the completing beat; s_ready returns the cycle after a take.
// Backpressure: single buffer drops s_ready while a vector is held; with PACKER_DOUBLE_BUF_EN one bank fills while the other is held.
module neuron_input_packer #(
  parameter int LANES = 62,
  parameter int DW    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_valid,
  input  logic [DW-1:0]       s_data,
  input  logic                s_last,
  output logic                s_ready,
  output logic                m_valid,
  output logic [LANES*DW-1:0] m_vec,
  output logic                m_short,
  input  logic                m_ready
);

  // Index width; LANES=1 still needs a 1-bit index that simply stays at 0.
  localparam int            IW       = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(LANES - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  // Sign bit set with zero magnitude: the redundant negative zero.
  localparam logic [DW-1:0] NEG_ZERO = {1'b1, {(DW-1){1'b0}}};

  logic          r_started;
  logic [IW-1:0] r_idx;
  logic [DW-1:0] w_norm;
  logic          w_accept;
  logic          w_complete;
  logic          w_short;
  logic          w_take;

  // Negative zero collapses to +0 so downstream MACs see one zero code.
  assign w_norm     = (s_data == NEG_ZERO) ? '0 : s_data;
  assign w_accept   = s_valid && s_ready;
  assign w_complete = s_last || (r_idx == LAST_IDX);
  assign w_short    = (r_idx != LAST_IDX);

  // Holds s_ready low during reset and until the first edge after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_started <= 1'b0;
    end else begin
      r_started <= 1'b1;
    end
  end

`ifdef PACKER_DOUBLE_BUF_EN

  // Two ping-pong banks: r_fill_sel is the bank being written, r_out_sel the
  // bank presented. They only coincide when both banks are empty or both are
  // full, so an accept and a take in the same cycle always hit different banks.
  logic [LANES*DW-1:0] r_bank [2];
  logic [1:0]          r_full;
  logic [1:0]          r_bshort;
  logic                r_fill_sel;
  logic                r_out_sel;

  assign s_ready = r_started && !r_full[r_fill_sel];
  assign m_valid = r_full[r_out_sel];
  assign m_vec   = r_bank[r_out_sel];
  assign m_short = r_bshort[r_out_sel];
  assign w_take  = m_valid && m_ready;

  // Bank fill, completion and release; a taken bank is zeroed so it refills clean.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        r_bank[b] <= '0;
      end
      r_full     <= '0;
      r_bshort   <= '0;
      r_fill_sel <= 1'b0;
      r_out_sel  <= 1'b0;
      r_idx      <= '0;
    end else begin
      if (w_take) begin
        r_bank[r_out_sel]   <= '0;
        r_full[r_out_sel]   <= 1'b0;
        r_bshort[r_out_sel] <= 1'b0;
        r_out_sel           <= ~r_out_sel;
      end
      if (w_accept) begin
        for (int i = 0; i < LANES; i++) begin
          if (r_idx == IW'(i)) begin
            r_bank[r_fill_sel][i*DW +: DW] <= w_norm;
          end
        end
        if (w_complete) begin
          r_full[r_fill_sel]   <= 1'b1;
          r_bshort[r_fill_sel] <= w_short;
          r_fill_sel           <= ~r_fill_sel;
          r_idx                <= '0;
        end else begin
          r_idx <= r_idx + IDX_ONE;
        end
      end
    end
  end

`else

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [LANES*DW-1:0] r_buf;
  logic                r_short;

  assign m_vec   = r_buf;
  assign m_short = r_short;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and handshake outputs; m_ready is only looked at while FULL.
  always_comb begin
    w_state_nxt = r_state;
    s_ready     = 1'b0;
    m_valid     = 1'b0;
    w_take      = 1'b0;
    unique case (r_state)
      ST_FILL: begin
        s_ready = r_started;
        if (s_valid && r_started && w_complete) begin
          w_state_nxt = ST_FULL;
        end
      end
      ST_FULL: begin
        m_valid = 1'b1;
        w_take  = m_ready;
        if (m_ready) begin
          w_state_nxt = ST_FILL;
        end
      end
      default: begin
        w_state_nxt = ST_FILL;
      end
    endcase
  end

  // Lane writes while filling; buffer zeroed on take so short vectors pad with 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf   <= '0;
      r_short <= 1'b0;
      r_idx   <= '0;
    end else if (w_take) begin
      r_buf   <= '0;
      r_short <= 1'b0;
    end else if (w_accept) begin
      for (int i = 0; i < LANES; i++) begin
        if (r_idx == IW'(i)) begin
          r_buf[i*DW +: DW] <= w_norm;
        end
      end
      if (w_complete) begin
        r_short <= w_short;
        r_idx   <= '0;
      end else begin
        r_idx <= r_idx + IDX_ONE;
      end
    end
  end

`endif

endmodule
